// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential fetch front end with a PC-tagged FIFO and redirect flush.
// Optional performance counters: define IFETCH_BUFFER_PERF_EN.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef IFETCH_BUFFER_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_inflight;
    logic [CW-1:0] w_used;
    logic          w_credit;
    logic          w_resp_live;
    logic          w_issue_slot;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_resp_pc;

    assign w_inflight   = (r_state == S_WAIT);
    assign w_used       = r_count + CW'(w_inflight);
    assign w_credit     = (w_used < CW'(DEPTH));
    assign w_resp_live  = mem_resp_valid && ((r_state == S_WAIT) || (r_state == S_DROP));
    assign w_issue_slot = (r_state == S_IDLE) || w_resp_live;

    assign mem_req_valid = w_issue_slot && w_credit && !redirect_valid && !rst;
    assign mem_req_addr  = r_fetch_pc;
    assign w_accept      = mem_req_valid && mem_req_ready;

    // fetch_pc has already advanced past the single outstanding request while in WAIT
    assign w_resp_pc = r_fetch_pc - 32'd4;
    assign w_push    = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;

    assign out_valid = !rst && (r_count != '0);
    assign out_inst  = rst ? '0 : r_inst[r_rd_ptr];
    assign out_pc    = rst ? '0 : r_pc[r_rd_ptr];
    assign w_pop     = out_valid && out_ready && !redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == 2'd3) begin
            w_state_nxt = S_IDLE;
        end else if (redirect_valid) begin
            if (w_resp_live) begin
                w_state_nxt = S_IDLE;
            end else if (r_state == S_WAIT) begin
                w_state_nxt = S_DROP;
            end
        end else if (w_accept) begin
            w_state_nxt = S_WAIT;
        end else if (w_resp_live) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_inst[r_wr_ptr] <= mem_resp_data;
                    r_pc[r_wr_ptr]   <= w_resp_pc;
                    r_wr_ptr         <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // The credit rule makes a push into a full FIFO unreachable
    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == CW'(DEPTH))));

`ifdef IFETCH_BUFFER_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic        w_drop_resp;

    assign w_drop_resp = mem_resp_valid &&
                         ((r_state == S_DROP) || ((r_state == S_WAIT) && redirect_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            r_perf_fetch <= r_perf_fetch + 32'(w_accept);
            r_perf_flush <= r_perf_flush + 32'(redirect_valid) + 32'(w_drop_resp);
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
